// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative MULT/MULTU/DIV/DIVU engine owning HI/LO.
// Ports: clk, reset(async low), start/op/a/b, mthi/mtlo, flush -> busy, done, hi, lo.
module muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNTW  = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_FIX,
    S_DONE
  } state_t;

  state_t             state;
  logic [CNTW-1:0]    cnt;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   opnd;
  logic               neg_q;
  logic               neg_r;
  logic               dbz;
  logic               op_div;

  logic               sgn;
  logic               b_zero;
  logic [WIDTH-1:0]   ma;
  logic [WIDTH-1:0]   mb;

  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     div_trial;
  logic [WIDTH:0]     div_diff;
  logic               div_ge;
  logic [2*WIDTH-1:0] div_next;

  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   rem;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;

  assign sgn    = ~op[0];
  assign b_zero = (b == '0);
  assign ma     = (sgn && a[WIDTH-1]) ? -a : a;
  assign mb     = (sgn && b[WIDTH-1]) ? -b : b;

  // acc = {upper partial product, remaining multiplier bits}
  assign mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]}
                 + (acc[0] ? {1'b0, opnd} : '0);
  assign mul_next = {mul_sum, acc[WIDTH-1:1]};

  // acc = {partial remainder, dividend bits / quotient bits}
  assign div_trial = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
  assign div_diff  = div_trial - {1'b0, opnd};
  // full compare so a zero divisor just shifts the dividend into rem
  assign div_ge    = (div_trial >= {1'b0, opnd});
  assign div_next  = div_ge
    ? {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1}
    : {div_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};

  assign quo      = acc[WIDTH-1:0];
  assign rem      = acc[2*WIDTH-1:WIDTH];
  assign prod_fix = neg_q ? -acc : acc;
  assign quo_fix  = dbz ? '1 : (neg_q ? -quo : quo);
  assign rem_fix  = neg_r ? -rem : rem;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= S_IDLE;
      cnt    <= '0;
      acc    <= '0;
      opnd   <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      dbz    <= 1'b0;
      op_div <= 1'b0;
      hi     <= '0;
      lo     <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            state  <= op[1] ? S_DIV : S_MUL;
            busy   <= 1'b1;
            cnt    <= '0;
            op_div <= op[1];
            acc    <= {{WIDTH{1'b0}}, (op[1] ? ma : mb)};
            opnd   <= op[1] ? mb : ma;
            // a zero divisor reports HI=a, so its quotient sign is moot
            neg_q  <= sgn & (a[WIDTH-1] ^ b[WIDTH-1])
                    & ~(op[1] & b_zero);
            neg_r  <= sgn & a[WIDTH-1];
            dbz    <= op[1] & b_zero;
          end else begin
            if (mthi) hi <= a;
            if (mtlo) lo <= a;
          end
        end
        S_MUL, S_DIV: begin
          if (flush) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else begin
            acc <= (state == S_DIV) ? div_next : mul_next;
            cnt <= cnt + CNTW'(1);
            if (cnt == '1) state <= S_FIX;
          end
        end
        S_FIX: begin
          if (flush) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else begin
            if (op_div) begin
              hi <= rem_fix;
              lo <= quo_fix;
            end else begin
              hi <= prod_fix[2*WIDTH-1:WIDTH];
              lo <= prod_fix[WIDTH-1:0];
            end
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        S_DONE: state <= S_IDLE;
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed vectors for muldiv_unit.
// Transaction-level model compared every cycle plus literal result checks.
module tb_muldiv_unit;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        mthi;
  logic        mtlo;
  logic        flush;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks = 0;
  int errors = 0;
  int nfail_print = 0;

  muldiv_unit #(.WIDTH(32), .CNTW(5)) dut (
    .clk   (clk),
    .reset (rst_n),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .mthi  (mthi),
    .mtlo  (mtlo),
    .flush (flush),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (nfail_print < 40) begin
        nfail_print++;
        $display("FAIL %s: got %h expected %h at %0t",
                 nm, act, exp, $time);
      end
    end
  endtask

  // architectural result {hi,lo} from plain arithmetic
  function automatic logic [63:0] model(input logic [1:0]  o,
                                        input logic [31:0] x,
                                        input logic [31:0] y);
    longint sx, sy, q, m;
    logic [63:0] r;
    sx = $signed(x);
    sy = $signed(y);
    r  = '0;
    case (o)
      2'b00: r = sx * sy;
      2'b01: r = {32'd0, x} * {32'd0, y};
      2'b10: begin
        if (y == 0) r = {x, 32'hFFFF_FFFF};
        else begin
          q = sx / sy;
          m = sx % sy;
          r = {m[31:0], q[31:0]};
        end
      end
      default: begin
        if (y == 0) r = {x, 32'hFFFF_FFFF};
        else r = {x % y, x / y};
      end
    endcase
    return r;
  endfunction

  // model: an op occupies the unit for 33 cycles after its start edge
  int          m_left;
  logic        m_done;
  logic [31:0] m_hi, m_lo, p_hi, p_lo;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_left <= 0;
      m_done <= 1'b0;
      m_hi   <= '0;
      m_lo   <= '0;
      p_hi   <= '0;
      p_lo   <= '0;
    end else begin
      m_done <= 1'b0;
      if (m_left > 0) begin
        if (flush) m_left <= 0;
        else begin
          m_left <= m_left - 1;
          if (m_left == 1) begin
            m_hi   <= p_hi;
            m_lo   <= p_lo;
            m_done <= 1'b1;
          end
        end
      end else if (!m_done) begin
        if (start) begin
          {p_hi, p_lo} <= model(op, a, b);
          m_left       <= 33;
        end else begin
          if (mthi) m_hi <= a;
          if (mtlo) m_lo <= a;
        end
      end
    end
  end

  always @(negedge clk) begin
    check("cyc_hi", hi, m_hi);
    check("cyc_lo", lo, m_lo);
    check("cyc_busy", {31'd0, busy}, {31'd0, (m_left > 0)});
    check("cyc_done", {31'd0, done}, {31'd0, m_done});
  end

  task automatic run_op(input logic [1:0]  o,
                        input logic [31:0] x,
                        input logic [31:0] y,
                        input logic [31:0] eh,
                        input logic [31:0] el,
                        input string       nm,
                        input int          flush_at,
                        input int          mt_at,
                        input logic        mt_start);
    int lat, nbusy;
    logic got;
    lat   = 0;
    nbusy = 0;
    got   = 1'b0;
    @(negedge clk);
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    mthi  = mt_start;
    mtlo  = mt_start;
    for (int n = 1; n <= 60; n++) begin
      @(negedge clk);
      if (n == 1) begin
        start = 1'b0;
        op    = ~o;
        a     = $urandom;
        b     = $urandom;
      end
      if (busy) nbusy++;
      if (done) begin
        got = 1'b1;
        lat = n;
        break;
      end
      flush = (n == flush_at);
      mthi  = (n == mt_at);
      mtlo  = (n == mt_at);
      if (flush_at > 0 && n == flush_at + 3) break;
    end
    flush = 1'b0;
    mthi  = 1'b0;
    mtlo  = 1'b0;
    if (flush_at > 0) begin
      check({nm, "_nodone"}, {31'd0, got}, 32'd0);
      check({nm, "_busy"}, {31'd0, busy}, 32'd0);
    end else begin
      check({nm, "_timeout"}, {31'd0, got}, 32'd1);
      check({nm, "_lat"}, lat, 34);
      check({nm, "_nbusy"}, nbusy, 33);
    end
    check({nm, "_hi"}, hi, eh);
    check({nm, "_lo"}, lo, el);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    op    = 2'b00;
    a     = '0;
    b     = '0;
    mthi  = 1'b0;
    mtlo  = 1'b0;
    flush = 1'b0;
    #22;
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    @(negedge clk);
    mthi = 1'b1;
    a    = 32'hAAAA_0000;
    @(negedge clk);
    mthi = 1'b0;
    check("mthi", hi, 32'hAAAA_0000);
    mtlo = 1'b1;
    a    = 32'h1234_5678;
    @(negedge clk);
    mtlo = 1'b0;
    check("mtlo", lo, 32'h1234_5678);
    check("mtlo_hi_kept", hi, 32'hAAAA_0000);
    mthi = 1'b1;
    mtlo = 1'b1;
    a    = 32'h0000_1111;
    @(negedge clk);
    mthi = 1'b0;
    mtlo = 1'b0;
    check("mt_both_hi", hi, 32'h0000_1111);
    check("mt_both_lo", lo, 32'h0000_1111);

    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
           32'hFFFF_FFFE, 32'h0000_0001, "multu_max", 0, 0, 1'b1);
    run_op(2'b00, 32'hFFFF_FFFD, 32'd5,
           32'hFFFF_FFFF, 32'hFFFF_FFF1, "mult_neg", 0, 10, 1'b0);
    run_op(2'b10, 32'hFFFF_FFF9, 32'd2,
           32'hFFFF_FFFF, 32'hFFFF_FFFD, "div_neg_a", 0, 0, 1'b0);
    run_op(2'b10, 32'd7, 32'hFFFF_FFFE,
           32'h0000_0001, 32'hFFFF_FFFD, "div_neg_b", 0, 0, 1'b0);
    run_op(2'b11, 32'd100, 32'd7,
           32'd2, 32'd14, "divu", 0, 0, 1'b0);

    // still in the DONE cycle: start and mthi must be dropped
    start = 1'b1;
    op    = 2'b00;
    a     = 32'd5;
    b     = 32'd5;
    mthi  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    mthi  = 1'b0;
    check("done_start_busy", {31'd0, busy}, 32'd0);
    check("done_mthi_hi", hi, 32'd2);

    run_op(2'b11, 32'h0000_1234, 32'd0,
           32'h0000_1234, 32'hFFFF_FFFF, "divu_by0", 0, 0, 1'b0);
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF,
           32'd0, 32'h8000_0000, "div_ovf", 0, 0, 1'b0);
    run_op(2'b10, 32'hFFFF_FFF9, 32'd0,
           32'hFFFF_FFF9, 32'hFFFF_FFFF, "div_by0", 0, 0, 1'b0);
    run_op(2'b00, 32'h8000_0000, 32'h8000_0000,
           32'h4000_0000, 32'd0, "mult_min", 0, 0, 1'b0);
    run_op(2'b10, 32'd1000, 32'd3,
           32'h4000_0000, 32'd0, "div_flush", 20, 0, 1'b0);

    // asynchronous reset in the middle of a multiply
    @(negedge clk);
    start = 1'b1;
    op    = 2'b00;
    a     = 32'd3;
    b     = 32'd4;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    check("pre_rst_busy", {31'd0, busy}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_hi", hi, 32'd0);
    check("arst_lo", lo, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("post_rst_busy", {31'd0, busy}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
